// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: drives the shared addroundkey unit and the round-transform
// unit through one encryption (ARK, then NR x {RT, ARK}) with per-step timeout.
module aes_round_ctrl #(
  parameter int NR       = 10,
  parameter int WAIT_MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] block_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] block_out,
  output logic         ark_start,
  output logic [127:0] ark_state,
  output logic [3:0]   ark_round,
  input  logic [127:0] ark_result,
  input  logic         ark_finish,
  output logic         rt_start,
  output logic [127:0] rt_state,
  output logic         rt_last,
  input  logic [127:0] rt_result,
  input  logic         rt_finish
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARK_ISSUE = 3'd1;
  localparam logic [2:0] S_ARK_WAIT  = 3'd2;
  localparam logic [2:0] S_RT_ISSUE  = 3'd3;
  localparam logic [2:0] S_RT_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [3:0]    LAST_ROUND = 4'(NR);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_MAX - 1);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [127:0]  data_q, data_d;
  logic [127:0]  block_out_q, block_out_d;
  logic          err_q, err_d;

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    wait_d      = wait_q;
    data_d      = data_q;
    block_out_d = block_out_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = block_in;
          round_d = 4'd0;
          state_d = S_ARK_ISSUE;
        end
      end
      S_ARK_ISSUE: begin
        wait_d  = '0;
        state_d = S_ARK_WAIT;
      end
      S_ARK_WAIT: begin
        // A finish on the final wait cycle still wins over the timeout.
        if (ark_finish) begin
          data_d = ark_result;
          if (round_q == LAST_ROUND) begin
            // Load the output register here so block_out is valid during the done pulse.
            block_out_d = ark_result;
            state_d     = S_DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_RT_ISSUE;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_RT_ISSUE: begin
        wait_d  = '0;
        state_d = S_RT_WAIT;
      end
      S_RT_WAIT: begin
        if (rt_finish) begin
          data_d  = rt_result;
          state_d = S_ARK_ISSUE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      round_q     <= 4'd0;
      wait_q      <= '0;
      data_q      <= '0;
      block_out_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      wait_q      <= wait_d;
      data_q      <= data_d;
      block_out_q <= block_out_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign block_out = block_out_q;
  assign ark_start = (state_q == S_ARK_ISSUE);
  assign ark_state = data_q;
  assign ark_round = round_q;
  assign rt_start  = (state_q == S_RT_ISSUE);
  assign rt_state  = data_q;
  assign rt_last   = ((state_q == S_RT_ISSUE) || (state_q == S_RT_WAIT)) && (round_q == LAST_ROUND);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES unit models around the sequencer,
// directed runs on the FIPS-197 C.1 vector.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] block_in;
  logic         busy, done, err;
  logic [127:0] block_out;
  logic         ark_start;
  logic [127:0] ark_state;
  logic [3:0]   ark_round;
  logic [127:0] ark_result;
  logic         ark_finish;
  logic         rt_start;
  logic [127:0] rt_state;
  logic         rt_last;
  logic [127:0] rt_result;
  logic         rt_finish;

  aes_round_ctrl #(.NR(10), .WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .start(start), .block_in(block_in),
    .busy(busy), .done(done), .err(err), .block_out(block_out),
    .ark_start(ark_start), .ark_state(ark_state), .ark_round(ark_round),
    .ark_result(ark_result), .ark_finish(ark_finish),
    .rt_start(rt_start), .rt_state(rt_state), .rt_last(rt_last),
    .rt_result(rt_result), .rt_finish(rt_finish)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, b, e, s;
    r = 8'h01; b = x; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] rt_fn(input logic [127:0] s, input logic last);
    logic [7:0]   b [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r + 4*c] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
    return o;
  endfunction

  logic [127:0] rk [0:10];

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- unit models + pulse monitor ----------------
  bit  rand_mode = 0;
  bit  stray_en  = 0;
  int  stuck_abs = -1;
  int  ark_cnt = 0, rt_cnt = 0;
  int  rt_pulses = 0, rt_last_n = 0, rt_last_at = 0;
  int  ark_q[$];
  logic [127:0] ark_pend, rt_pend;

  always @(negedge clk) begin
    bit rt_pending;
    int idx;
    ark_finish = 1'b0;
    rt_finish  = 1'b0;
    if (busy !== 1'b1) begin
      ark_cnt = 0;
      rt_cnt  = 0;
    end else begin
      rt_pending = (rt_cnt > 0);
      if (ark_cnt > 0) begin
        ark_cnt--;
        if (ark_cnt == 0) begin
          ark_finish = 1'b1;
          ark_result = ark_pend;
        end
      end
      if (rt_cnt > 0) begin
        rt_cnt--;
        if (rt_cnt == 0) begin
          rt_finish = 1'b1;
          rt_result = rt_pend;
        end
      end
      if (stray_en && rt_pending && !ark_finish && $urandom_range(0, 1) == 1) begin
        ark_finish = 1'b1;
        ark_result = {$urandom, $urandom, $urandom, $urandom};
      end
      if (ark_start) begin
        ark_q.push_back(int'(ark_round));
        idx = int'(ark_round);
        if (idx > 10) idx = 0;
        ark_pend = ark_state ^ rk[idx];
        ark_cnt  = rand_mode ? int'($urandom_range(1, 8)) : 1;
      end
      if (rt_start) begin
        rt_pulses++;
        if (rt_last) begin
          rt_last_n++;
          rt_last_at = rt_pulses;
        end
        if (rt_pulses != stuck_abs) begin
          rt_pend = rt_fn(rt_state, rt_last);
          rt_cnt  = rand_mode ? int'($urandom_range(1, 8)) : 1;
        end
      end
    end
  end

  // ---------------- per-operation run ----------------
  bit busy_h [0:399];
  bit done_h [0:399];
  bit err_h  [0:399];
  bit ark_h  [0:399];
  int done_n, err_n, busy_n, busy_first, busy_last, done_first;
  int ark_base, rt_base, rt_last_base;
  logic [127:0] bo_end;
  logic [9:0]   snap_ctl;
  logic [127:0] snap_bo, snap_as, snap_rs;

  task automatic run_op(input logic [127:0] blk, input bit hold, input int pulse_cyc,
                        input int rst_cyc, input int ncyc, input int stuck_rel);
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      busy_h[i] = 0; done_h[i] = 0; err_h[i] = 0; ark_h[i] = 0;
    end
    done_n = 0; err_n = 0; busy_n = 0; busy_first = 0; busy_last = 0; done_first = 0;
    ark_base = ark_q.size(); rt_base = rt_pulses; rt_last_base = rt_last_n;
    stuck_abs = (stuck_rel > 0) ? rt_pulses + stuck_rel : -1;
    block_in = blk;
    start = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      busy_h[cyc] = busy; done_h[cyc] = done; err_h[cyc] = err; ark_h[cyc] = ark_start;
      if (busy === 1'b1) begin
        busy_n++;
        if (busy_first == 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done === 1'b1) begin
        done_n++;
        if (done_first == 0) done_first = cyc;
      end
      if (err === 1'b1) err_n++;
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        snap_ctl = {busy, done, err, ark_start, rt_start, rt_last, ark_round};
        snap_bo = block_out; snap_as = ark_state; snap_rs = rt_state;
        rst = 1'b1;
      end
      if (rst_cyc > 0 && cyc == rst_cyc) rst = 1'b0;
      if (cyc == ncyc) bo_end = block_out;
      start = hold || (cyc == pulse_cyc);
    end
    start = 1'b0;
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
    check_eq("drain_idle", 128'(busy), 128'(0));
    @(negedge clk);
    stuck_abs = -1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; start = 1'b0; block_in = '0;
    ark_result = '0; ark_finish = 1'b0; rt_result = '0; rt_finish = 1'b0;
    expand_key(KEY);

    repeat (3) @(negedge clk);
    check_eq("reset_ctl", 128'({busy, done, err, ark_start, rt_start, rt_last, ark_round}), 128'(0));
    check_eq("reset_block_out", block_out, 128'(0));
    rst = 1'b1;

    // FIPS-197 C.1, 1-cycle units
    run_op(PT, 0, 0, 0, 50, 0);
    check_eq("fips_done_cycle", 128'(done_first), 128'(43));
    check_eq("fips_done_count", 128'(done_n), 128'(1));
    check_eq("fips_block_out", bo_end, CT);
    check_eq("fips_busy_first", 128'(busy_first), 128'(1));
    check_eq("fips_busy_last", 128'(busy_last), 128'(43));
    check_eq("fips_busy_count", 128'(busy_n), 128'(43));
    check_eq("fips_err_count", 128'(err_n), 128'(0));
    check_eq("fips_ark_pulses", 128'(ark_q.size() - ark_base), 128'(11));
    for (int i = 0; i < 11; i++)
      if (ark_base + i < ark_q.size())
        check_eq($sformatf("fips_ark_round%0d", i), 128'(ark_q[ark_base + i]), 128'(i));
    check_eq("fips_rt_pulses", 128'(rt_pulses - rt_base), 128'(10));
    check_eq("fips_rt_last_count", 128'(rt_last_n - rt_last_base), 128'(1));
    check_eq("fips_rt_last_at", 128'(rt_last_at - rt_base), 128'(10));

    // start held high: second op accepted only in the IDLE cycle after done
    run_op(PT, 1, 0, 0, 90, 0);
    check_eq("hold_done1", 128'(done_h[43]), 128'(1));
    check_eq("hold_idle44", 128'(busy_h[44]), 128'(0));
    check_eq("hold_ark45", 128'(ark_h[45]), 128'(1));
    check_eq("hold_done2", 128'(done_h[87]), 128'(1));
    check_eq("hold_done_count", 128'(done_n), 128'(2));
    check_eq("hold_idle88", 128'(busy_h[88]), 128'(0));
    check_eq("hold_block_out", bo_end, CT);

    // start pulse mid-operation ignored
    run_op(PT, 0, 10, 0, 60, 0);
    check_eq("pulse_done_count", 128'(done_n), 128'(1));
    check_eq("pulse_done_cycle", 128'(done_first), 128'(43));
    check_eq("pulse_busy_count", 128'(busy_n), 128'(43));

    // round-3 RT unit never finishes: RT_WAIT cycles 12..26, err in cycle 27
    run_op(128'h0123456789abcdeffedcba9876543210, 0, 0, 0, 40, 3);
    check_eq("tmo_err27", 128'(err_h[27]), 128'(1));
    check_eq("tmo_err26", 128'(err_h[26]), 128'(0));
    check_eq("tmo_err_count", 128'(err_n), 128'(1));
    check_eq("tmo_busy26", 128'(busy_h[26]), 128'(1));
    check_eq("tmo_busy27", 128'(busy_h[27]), 128'(0));
    check_eq("tmo_done_count", 128'(done_n), 128'(0));
    check_eq("tmo_block_out_kept", bo_end, CT);

    // reset asserted in round-5 RT_WAIT (cycle 20)
    run_op(PT, 0, 0, 20, 40, 0);
    check_eq("rstmid_ctl", 128'(snap_ctl), 128'(0));
    check_eq("rstmid_block_out", snap_bo, 128'(0));
    check_eq("rstmid_ark_state", snap_as, 128'(0));
    check_eq("rstmid_rt_state", snap_rs, 128'(0));
    check_eq("rstmid_done_count", 128'(done_n), 128'(0));
    check_eq("rstmid_err_count", 128'(err_n), 128'(0));
    run_op(PT, 0, 0, 0, 50, 0);
    check_eq("after_rst_done_cycle", 128'(done_first), 128'(43));
    check_eq("after_rst_block_out", bo_end, CT);

    // random 1..8-cycle unit latency with stray ark_finish during RT_WAIT
    rand_mode = 1; stray_en = 1;
    run_op(PT, 0, 0, 0, 300, 0);
    check_eq("rand_done_count", 128'(done_n), 128'(1));
    check_eq("rand_err_count", 128'(err_n), 128'(0));
    check_eq("rand_block_out", bo_end, CT);
    check_eq("rand_ark_pulses", 128'(ark_q.size() - ark_base), 128'(11));
    check_eq("rand_rt_pulses", 128'(rt_pulses - rt_base), 128'(10));
    rand_mode = 0; stray_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences one AES-128 encryption of a 128-bit block over the shared `addroundkey` unit and a round-transform unit (SubBytes+ShiftRows+MixColumns, MixColumns bypassed on the last round).
- Issues one-cycle start pulses, waits for each unit's finish, and steps the round number through 0..NR.
- Sits between the top-level block interface and the round datapath units.
- The expanded key is held externally and indexed by `ark_round`.

Parameters:
- NR, 10, number of cipher rounds; `ark_round` runs 0..NR.
- WAIT_MAX, 15, max cycles to wait for a unit finish before aborting with `err`.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low (0 = reset)
- start  input  1  begin encryption of `block_in`; sampled only in IDLE
- block_in  input  128  plaintext, captured when `start` is accepted
- busy  output  1  high from the cycle after `start` is accepted through the DONE cycle
- done  output  1  one-cycle pulse; `block_out` is valid
- err  output  1  one-cycle pulse on timeout abort
- block_out  output  128  ciphertext; held until the next accepted `start`
- ark_start  output  1  one-cycle start pulse to `addroundkey`
- ark_state  output  128  state fed to `addroundkey`
- ark_round  output  4  round number fed to `addroundkey`
- ark_result  input  128  `addroundkey` output
- ark_finish  input  1  `addroundkey` done
- rt_start  output  1  one-cycle start pulse to the round-transform unit
- rt_state  output  128  state fed to the round-transform unit
- rt_last  output  1  high for round NR (MixColumns skipped)
- rt_result  input  128  round-transform output
- rt_finish  input  1  round-transform done

Behaviour:
- Reset (rst=0 at posedge):
  - state returns to IDLE regardless of the current state.
  - All outputs go to 0, including `block_out`.
  - Round counter, wait counter and state register are cleared.
  - Reset mid-operation aborts the operation with no `done` or `err`.
- States: IDLE, ARK_ISSUE, ARK_WAIT, RT_ISSUE, RT_WAIT, DONE.
- IDLE:
  - `start`=1 captures `block_in` into the state register.
  - round counter is set to 0; next state is ARK_ISSUE.
- ARK_ISSUE:
  - `ark_start`=1 for this cycle only.
  - `ark_state`=state register, `ark_round`=round counter.
  - Next state is ARK_WAIT; wait counter is set to 0.
- ARK_WAIT:
  - `ark_state` and `ark_round` are held stable.
  - On `ark_finish`, `ark_result` is loaded into the state register.
  - If round=NR, next state is DONE.
  - Otherwise the round counter increments and next state is RT_ISSUE.
- RT_ISSUE:
  - `rt_start`=1 for one cycle; `rt_state`=state register.
  - `rt_last`=(round==NR).
  - Next state is RT_WAIT.
- RT_WAIT:
  - On `rt_finish`, `rt_result` is loaded into the state register; next state is ARK_ISSUE.
  - Round counter is unchanged.
- Timeout (both WAIT states):
  - Wait counter increments each cycle without a finish.
  - Reaching WAIT_MAX without a finish → `err`=1 for one cycle and next state is IDLE.
  - `block_out` is unchanged on abort.
- DONE:
  - `block_out`=state register, `done`=1 for one cycle.
  - Next state is IDLE.
- `busy`=1 in all states except IDLE.
- `start` while busy is ignored; it is not queued.
- A finish input arriving in any state other than its matching WAIT state is ignored.
- A finish arriving in the same cycle the wait counter reaches WAIT_MAX is accepted; the finish wins over the timeout.
- Step order:
  - round 0: ARK.
  - rounds 1..NR: RT, then ARK.
  - Total NR+1 ARK steps and NR RT steps.
- Latency with 1-cycle units (finish arrives in the cycle after the start pulse):
  - each step takes 2 cycles.
  - `done` is asserted exactly 2·(2·NR+1)+1 = 43 cycles after the edge that accepted `start`.
- `ark_round` never exceeds NR.
- Round counter is 4 bits wide and never wraps.

Test Plan:
- FIPS-197 C.1 vector: `block_in`=00112233445566778899aabbccddeeff, key 000102…0f expanded, 1-cycle unit models, `start` pulse → `done` 43 cycles later, `block_out`=69c4e0d86a7b0430d8cdb78070b4c55a, `busy` high for cycles 1..43.
- Sequence check on the same run:
  - `ark_round` sequence on `ark_start` pulses is 0,1,…,10.
  - exactly 10 `rt_start` pulses, with `rt_last`=1 only on the 10th.
- Back-to-back operation:
  - `start` held high continuously → second operation accepted only in the IDLE cycle after `done`.
  - `start` pulsed mid-operation is ignored and `done` count stays 1.
- Timeout: `rt_finish` model stuck at 0 on round 3 → `err` pulses one cycle after 15 wait cycles, `busy` drops, no `done`, `block_out` retains its previous value.
- Reset mid-operation: drive rst=0 during round 5 RT_WAIT → next cycle all outputs 0 and state IDLE; a new `start` then completes normally with the correct ciphertext.
- Variable-latency units: random 1–8-cycle finish delays → correct ciphertext; stray `ark_finish` pulses injected during RT_WAIT are ignored.
